pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Sequencing controller for the five-stage pipeline registers: generates per-stage stall and flush for the fetch/decode, decode/execute, execute/memory and memory/writeback registers. Resolves load-use hazards, branch mispredict redirects, I-cache refills and D-cache refills, including refills that overlap. Counts fetch-stall cycles for performance monitoring. Sits beside the datapath; purely a control block with no datapath storage.

Parameters:
REG_ADDR_WIDTH, 5, register specifier width
CNT_WIDTH, 32, stall-cycle counter width

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_arst  in  1  reset, synchronous active-high; clears all state on the next rising edge
i_icache_miss  in  1  fetch-stage I-cache miss this cycle
i_icache_done  in  1  I-cache refill complete, 1-cycle pulse
i_dcache_miss  in  1  memory-stage D-cache miss this cycle
i_dcache_done  in  1  D-cache refill complete, 1-cycle pulse
i_mispred_exe  in  1  branch/jump in execute redirects the PC
i_mem_read_exe  in  1  instruction in execute is a load
i_rd_exe  in  REG_ADDR_WIDTH  destination of the execute instruction
i_rs1_dec  in  REG_ADDR_WIDTH  source 1 of the decode instruction
i_rs2_dec  in  REG_ADDR_WIDTH  source 2 of the decode instruction
o_stall_fetch  out  1  hold PC
o_stall_dec  out  1  hold fetch/decode register
o_flush_dec  out  1  clear fetch/decode register
o_stall_exe  out  1  hold decode/execute register
o_flush_exe  out  1  clear decode/execute register
o_stall_mem  out  1  hold execute/memory register
o_flush_mem  out  1  clear execute/memory register
o_stall_wb  out  1  hold memory/writeback register
o_state  out  2  current FSM state encoding
o_stall_cnt  out  CNT_WIDTH  fetch-stall cycle count

Behaviour:
- Reset: state RUN, icache_pend 0, o_stall_cnt 0. Reset dominates all inputs, including mid-refill.
- State: RUN=0, IWAIT=1, DWAIT=2. Flag icache_pend: set when IWAIT is entered; cleared by i_icache_done in any state.
- All stall/flush outputs are combinational from the current state and inputs. Any signal not listed for a case is 0. Flush and stall on the same register are never both 1.
- Per-cycle priority: D-cache > mispredict > load-use > I-cache.
- D-cache condition is (state==DWAIT) or (state!=DWAIT and i_dcache_miss). When it holds:
  - all stalls are 1 and no flushes.
  - RUN/IWAIT with i_dcache_miss: next state DWAIT; icache_pend is retained.
  - DWAIT with i_dcache_done: next state IWAIT if icache_pend (after this cycle's done-clear), else RUN.
- RUN with i_mispred_exe: flush_dec=1, flush_exe=1, stall_fetch=0.
  - If i_icache_miss is also 1: next state IWAIT; the PC still loads the target, and fetch retries after the refill.
- RUN, load-use: i_mem_read_exe, i_rd_exe!=0, and i_rd_exe equals i_rs1_dec or i_rs2_dec:
  - stall_fetch=1, stall_dec=1, flush_exe=1.
  - If i_icache_miss is also 1: next state IWAIT.
- RUN with i_icache_miss only: stall_fetch=1, flush_dec=1; next state IWAIT.
- IWAIT:
  - stall_fetch=1 and flush_dec=1 (bubbles into decode); downstream proceeds.
  - If i_mispred_exe: additionally stall_exe=1 and flush_mem=1. The branch is held in execute until refill ends and is redirected in RUN.
  - Load-use in IWAIT needs no action: the decode register holds a bubble.
  - i_icache_done: next state RUN; the outputs that cycle are still IWAIT outputs.
- i_icache_done in RUN is ignored.
- A new i_icache_miss while in DWAIT is ignored; the fetch retries later.
- Counter: o_stall_cnt += 1 on each cycle with o_stall_fetch=1. It saturates at all-ones and never wraps.

Decomposition:
- Shared package pipeline_pkg holds:
  - typedef enum logic [1:0] ctrl_state_t {RUN, IWAIT, DWAIT}
  - constant REG_ADDR_WIDTH
- Sub-module hazard_detect: combinational load-use comparator, inputs i_mem_read_exe/i_rd_exe/i_rs1_dec/i_rs2_dec, output hazard bit.
- FSM, icache_pend and the counter stay in pipeline_ctrl.

Test Plan:
- Load-use: rd_exe=5, mem_read=1, rs1_dec=5, RUN → stall_fetch=stall_dec=flush_exe=1 for one cycle. Same stimulus with rd_exe=0 → all outputs 0.
- Mispredict plus load-use in the same cycle → flush_dec=flush_exe=1, stall_fetch=0, state stays RUN.
- I-cache miss, done after 4 cycles → state IWAIT for 4 cycles with stall_fetch=flush_dec=1. RUN follows, o_stall_cnt=5 (miss cycle plus 4 IWAIT cycles).
- I-cache miss, D-cache miss 1 cycle later, icache_done during DWAIT, dcache_done 3 cycles later → all stalls 1 throughout DWAIT, then RUN (icache_pend cleared). Repeat without icache_done → returns to IWAIT.
- IWAIT with mispred_exe=1 → stall_exe=flush_mem=1. After icache_done, RUN with flush_dec=flush_exe=1.
- Reset asserted during DWAIT → next edge: state RUN, o_stall_cnt 0, all outputs 0. Counter preset near all-ones saturates.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline sequencing controller
package pipeline_pkg;

  // Register specifier width used by the hazard comparator
  localparam int REG_ADDR_WIDTH = 5;

  // Controller states: normal flow, waiting on I-cache refill, waiting on D-cache refill
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2
  } ctrl_state_t;

  // Per-register control bundle driven by the controller each cycle
  typedef struct packed {
    logic stall_fetch;
    logic stall_dec;
    logic flush_dec;
    logic stall_exe;
    logic flush_exe;
    logic stall_mem;
    logic flush_mem;
    logic stall_wb;
  } ctrl_out_t;

  // Every stage holds, nothing is cleared
  localparam ctrl_out_t CTRL_ALL_STALL = '{
    stall_fetch: 1'b1, stall_dec: 1'b1, flush_dec: 1'b0, stall_exe: 1'b1,
    flush_exe: 1'b0, stall_mem: 1'b1, flush_mem: 1'b0, stall_wb: 1'b1
  };

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard comparator between execute and decode
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_WIDTH
) (
  input  logic              i_mem_read_exe,
  input  logic [ADDR_W-1:0] i_rd_exe,
  input  logic [ADDR_W-1:0] i_rs1_dec,
  input  logic [ADDR_W-1:0] i_rs2_dec,
  output logic              o_hazard
);

  // A load into x0 never creates a dependency, so rd==0 is excluded
  always_comb begin
    o_hazard = i_mem_read_exe && (i_rd_exe != '0) &&
               ((i_rd_exe == i_rs1_dec) || (i_rd_exe == i_rs2_dec));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencing for the five-stage pipeline registers
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = pipeline_pkg::REG_ADDR_WIDTH,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_icache_miss,
  input  logic                      i_icache_done,
  input  logic                      i_dcache_miss,
  input  logic                      i_dcache_done,
  input  logic                      i_mispred_exe,
  input  logic                      i_mem_read_exe,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_exe,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1_dec,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2_dec,
  output logic                      o_stall_fetch,
  output logic                      o_stall_dec,
  output logic                      o_flush_dec,
  output logic                      o_stall_exe,
  output logic                      o_flush_exe,
  output logic                      o_stall_mem,
  output logic                      o_flush_mem,
  output logic                      o_stall_wb,
  output logic [1:0]                o_state,
  output logic [CNT_WIDTH-1:0]      o_stall_cnt
);

  ctrl_state_t          state_q, state_d;
  logic                 icache_pend_q, icache_pend_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 load_use;
  logic                 dcache_hold;
  ctrl_out_t            ctl;

  hazard_detect #(
    .ADDR_W (REG_ADDR_WIDTH)
  ) u_hazard (
    .i_mem_read_exe (i_mem_read_exe),
    .i_rd_exe       (i_rd_exe),
    .i_rs1_dec      (i_rs1_dec),
    .i_rs2_dec      (i_rs2_dec),
    .o_hazard       (load_use)
  );

  // A D-cache miss freezes the whole pipe, whether it is just arriving or already pending
  assign dcache_hold = (state_q == DWAIT) || i_dcache_miss;

  // Next-state and stall/flush decode, priority D-cache > mispredict > load-use > I-cache
  always_comb begin
    state_d       = state_q;
    icache_pend_d = icache_pend_q && !i_icache_done;
    ctl           = '0;

    if (dcache_hold) begin
      ctl = CTRL_ALL_STALL;
      if (state_q != DWAIT) begin
        state_d = DWAIT;
      end else if (i_dcache_done) begin
        // Resume the I-cache wait only if its refill has not already finished
        state_d = icache_pend_d ? IWAIT : RUN;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (i_mispred_exe) begin
            // PC takes the branch target; wrong-path instructions are dropped
            ctl.flush_dec = 1'b1;
            ctl.flush_exe = 1'b1;
            if (i_icache_miss) state_d = IWAIT;
          end else if (load_use) begin
            ctl.stall_fetch = 1'b1;
            ctl.stall_dec   = 1'b1;
            ctl.flush_exe   = 1'b1;
            if (i_icache_miss) state_d = IWAIT;
          end else if (i_icache_miss) begin
            ctl.stall_fetch = 1'b1;
            ctl.flush_dec   = 1'b1;
            state_d         = IWAIT;
          end
        end
        IWAIT: begin
          ctl.stall_fetch = 1'b1;
          ctl.flush_dec   = 1'b1;
          if (i_mispred_exe) begin
            // Park the branch in execute; it redirects once fetch is back in RUN
            ctl.stall_exe = 1'b1;
            ctl.flush_mem = 1'b1;
          end
          if (i_icache_done) state_d = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    if ((state_d == IWAIT) && (state_q != IWAIT)) begin
      icache_pend_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (ctl.stall_fetch && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, pending-refill flag and saturating fetch-stall counter
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q       <= RUN;
      icache_pend_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      icache_pend_q <= icache_pend_d;
      cnt_q         <= cnt_d;
    end
  end

  assign o_stall_fetch = ctl.stall_fetch;
  assign o_stall_dec   = ctl.stall_dec;
  assign o_flush_dec   = ctl.flush_dec;
  assign o_stall_exe   = ctl.stall_exe;
  assign o_flush_exe   = ctl.flush_exe;
  assign o_stall_mem   = ctl.stall_mem;
  assign o_flush_mem   = ctl.flush_mem;
  assign o_stall_wb    = ctl.stall_wb;
  assign o_state       = state_q;
  assign o_stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - randomized and directed checks of pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

  localparam int AW = 5;
  localparam int CW = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          arst;
  logic          icache_miss, icache_done, dcache_miss, dcache_done;
  logic          mispred, mem_read;
  logic [AW-1:0] rd_exe, rs1_dec, rs2_dec;
  logic          stall_fetch, stall_dec, flush_dec, stall_exe, flush_exe;
  logic          stall_mem, flush_mem, stall_wb;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // Behavioural model: 0 = running, 1 = waiting I-refill, 2 = waiting D-refill
  int  m_mode;
  bit  m_ipend;
  int  m_cnt;

  logic [7:0]    obs_out;
  logic [1:0]    obs_state;
  logic [CW-1:0] obs_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .REG_ADDR_WIDTH (AW),
    .CNT_WIDTH      (CW)
  ) dut (
    .i_clk          (clk),
    .i_arst         (arst),
    .i_icache_miss  (icache_miss),
    .i_icache_done  (icache_done),
    .i_dcache_miss  (dcache_miss),
    .i_dcache_done  (dcache_done),
    .i_mispred_exe  (mispred),
    .i_mem_read_exe (mem_read),
    .i_rd_exe       (rd_exe),
    .i_rs1_dec      (rs1_dec),
    .i_rs2_dec      (rs2_dec),
    .o_stall_fetch  (stall_fetch),
    .o_stall_dec    (stall_dec),
    .o_flush_dec    (flush_dec),
    .o_stall_exe    (stall_exe),
    .o_flush_exe    (flush_exe),
    .o_stall_mem    (stall_mem),
    .o_flush_mem    (flush_mem),
    .o_stall_wb     (stall_wb),
    .o_state        (state),
    .o_stall_cnt    (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs mid-cycle against the model, then advance the model
  task automatic step(input bit rst, input bit im, input bit id, input bit dm, input bit dd,
                      input bit mp, input bit mr, input logic [AW-1:0] rd,
                      input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    logic [7:0] exp;
    int  nxt;
    bit  pend_n;
    bit  lu;
    arst = rst; icache_miss = im; icache_done = id; dcache_miss = dm; dcache_done = dd;
    mispred = mp; mem_read = mr; rd_exe = rd; rs1_dec = s1; rs2_dec = s2;
    @(negedge clk);
    lu     = mr && (rd != 0) && ((rd == s1) || (rd == s2));
    exp    = 8'h00;
    nxt    = m_mode;
    pend_n = m_ipend && !id;
    // bit order: stall_fetch stall_dec flush_dec stall_exe flush_exe stall_mem flush_mem stall_wb
    if (m_mode == 2 || dm) begin
      exp = 8'b1101_0101;
      if (m_mode != 2) nxt = 2;
      else if (dd) nxt = pend_n ? 1 : 0;
    end else if (m_mode == 0) begin
      if (mp)      exp = 8'b0010_1000;
      else if (lu) exp = 8'b1100_1000;
      else if (im) exp = 8'b1010_0000;
      if (im) nxt = 1;
    end else begin
      exp = mp ? 8'b1011_0010 : 8'b1010_0000;
      if (id) nxt = 0;
    end
    if (nxt == 1 && m_mode != 1) pend_n = 1'b1;
    obs_out   = {stall_fetch, stall_dec, flush_dec, stall_exe, flush_exe, stall_mem, flush_mem, stall_wb};
    obs_state = state;
    obs_cnt   = stall_cnt;
    check("outputs", {24'h0, obs_out}, {24'h0, exp});
    check("state", {30'h0, obs_state}, m_mode);
    check("stall_cnt", {{(32-CW){1'b0}}, obs_cnt}, m_cnt);
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_ipend = 1'b0; m_cnt = 0;
    end else begin
      if (exp[7] && m_cnt < CNT_MAX) m_cnt++;
      m_mode  = nxt;
      m_ipend = pend_n;
    end
    #1;
  endtask

  task automatic idle(input bit im, input bit id, input bit dm, input bit dd, input bit mp);
    step(1'b0, im, id, dm, dd, mp, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    m_mode = 0; m_ipend = 1'b0; m_cnt = 0;
    arst = 1'b1; icache_miss = 0; icache_done = 0; dcache_miss = 0; dcache_done = 0;
    mispred = 0; mem_read = 0; rd_exe = 0; rs1_dec = 0; rs2_dec = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state
    idle(0, 0, 0, 0, 0);
    check("rst_out", {24'h0, obs_out}, 32'h0);

    // Load-use, then the same with rd=0
    step(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd9);
    check("lu_out", {24'h0, obs_out}, 32'hC8);
    step(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    check("lu_x0_out", {24'h0, obs_out}, 32'h0);

    // Mispredict wins over load-use
    step(0, 0, 0, 0, 0, 1, 1, 5'd7, 5'd3, 5'd7);
    check("mp_lu_out", {24'h0, obs_out}, 32'h28);
    idle(0, 0, 0, 0, 0);
    check("mp_lu_state", {30'h0, obs_state}, 32'd0);

    // I-miss with done on the fourth IWAIT cycle
    do_reset();
    idle(1, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 0);
    idle(0, 1, 0, 0, 0);
    check("imiss_iwait_out", {24'h0, obs_out}, 32'hA0);
    idle(0, 0, 0, 0, 0);
    check("imiss_cnt", {{(32-CW){1'b0}}, obs_cnt}, 32'd5);
    check("imiss_state", {30'h0, obs_state}, 32'd0);

    // Overlapping refills, I-refill finishes during DWAIT
    idle(1, 0, 0, 0, 0);
    idle(0, 0, 1, 0, 0);
    idle(0, 1, 0, 0, 0);
    check("dwait_out", {24'h0, obs_out}, 32'hD5);
    idle(0, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 0);
    idle(0, 0, 0, 1, 0);
    idle(0, 0, 0, 0, 0);
    check("overlap_run", {30'h0, obs_state}, 32'd0);

    // Overlapping refills, I-refill still pending after DWAIT
    idle(1, 0, 0, 0, 0);
    idle(0, 0, 1, 0, 0);
    idle(0, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 0);
    idle(0, 0, 0, 1, 0);
    idle(0, 0, 0, 0, 0);
    check("overlap_iwait", {30'h0, obs_state}, 32'd1);
    idle(0, 1, 0, 0, 0);

    // Mispredict parked during IWAIT, redirected in RUN
    idle(1, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 1);
    check("iwait_mp_out", {24'h0, obs_out}, 32'hB2);
    idle(0, 1, 0, 0, 1);
    idle(0, 0, 0, 0, 1);
    check("run_mp_out", {24'h0, obs_out}, 32'h28);

    // Reset during DWAIT
    idle(0, 0, 1, 0, 0);
    do_reset();
    idle(0, 0, 0, 0, 0);
    check("rst_dwait_state", {30'h0, obs_state}, 32'd0);
    check("rst_dwait_cnt", {{(32-CW){1'b0}}, obs_cnt}, 32'd0);
    check("rst_dwait_out", {24'h0, obs_out}, 32'h0);

    // Counter saturation through a long I-refill
    idle(1, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) idle(0, 0, 0, 0, 0);
    idle(0, 1, 0, 0, 0);
    idle(0, 0, 0, 0, 0);
    check("cnt_sat", {{(32-CW){1'b0}}, obs_cnt}, CNT_MAX);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 1) == 1),
           AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
